// File: rtl/vx_tcu_drl_norm_round.sv
// Normalize, RNE-round and pack the TCU DRL accumulator sum into fp32, or zero-extend it in integer mode.
// Latency: 3 cycles (S1 magnitude, S2 normalize, S3 round/pack into the output register).
// Backpressure: one global enable (~valid_out | ready_out) freezes every stage; ready_in mirrors it.
module vx_tcu_drl_norm_round #(
    parameter int N = 5,
    parameter int W = 25 + $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         valid_in,
    output logic         ready_in,
    input  logic [W-1:0] sig_in,
    input  logic [7:0]   exp_in,
    input  logic         fmt_sel,
    output logic         valid_out,
    input  logic         ready_out,
    output logic [31:0]  result,
    output logic [2:0]   flags
);

    localparam int LZW = $clog2(W + 1);

    typedef struct packed {
        logic         sign;
        logic         fmt;
        logic [7:0]   exp;
        logic [W-1:0] mag;
    } s1_t;

    typedef struct packed {
        logic         sign;
        logic         fmt;
        logic         zero;
        logic [9:0]   e_pre;
        logic [W-1:0] norm;
    } s2_t;

    logic en;
    logic v1, v2;
    s1_t  s1, s1_d;
    s2_t  s2, s2_d;

    assign en       = ~valid_out | ready_out;
    assign ready_in = en;

    function automatic logic [LZW-1:0] lzc_f(input logic [W-1:0] x);
        lzc_f = LZW'(W);
        // Ascending scan: the highest set bit is the last to overwrite.
        for (int i = 0; i < W; i++) begin
            if (x[i]) lzc_f = LZW'(W - 1 - i);
        end
    endfunction

    // S1: sign/magnitude split; integer beats carry the raw word in the mag field.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = sig_in[W-1] & ~fmt_sel;
        s1_d.fmt  = fmt_sel;
        s1_d.exp  = exp_in;
        s1_d.mag  = (fmt_sel | ~sig_in[W-1]) ? sig_in : -sig_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else if (en) begin
            v1 <= valid_in;
            s1 <= s1_d;
        end
    end

    // S2: normalize so the leading one lands in bit W-1.
    logic [LZW-1:0] lz;

    always_comb begin
        lz         = lzc_f(s1.mag);
        s2_d       = '0;
        s2_d.sign  = s1.sign;
        s2_d.fmt   = s1.fmt;
        s2_d.zero  = (s1.mag == '0) | (s1.exp == 8'd0);
        s2_d.e_pre = 10'(s1.exp) + 10'(W - 24) - 10'(lz);
        s2_d.norm  = s1.fmt ? s1.mag : (s1.mag << lz);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2 <= 1'b0;
            s2 <= '0;
        end else if (en) begin
            v2 <= v1;
            s2 <= s2_d;
        end
    end

    // S3: round to nearest even, then classify overflow / FTZ underflow / zero.
    logic [22:0] mant;
    logic        guard, sticky, rnd;
    logic [23:0] mant_inc;
    logic [9:0]  e_rnd;
    logic [31:0] int_word;
    logic [31:0] res_d;
    logic [2:0]  flg_d;

    generate
        if (W >= 32) begin : g_int_trunc
            assign int_word = s2.norm[31:0];
        end else begin : g_int_zext
            assign int_word = {{(32 - W){1'b0}}, s2.norm};
        end
    endgenerate

    always_comb begin
        mant     = s2.norm[W-2 -: 23];
        guard    = s2.norm[W-25];
        sticky   = |s2.norm[W-26:0];
        rnd      = guard & (sticky | mant[0]);
        mant_inc = {1'b0, mant} + {23'd0, rnd};
        e_rnd    = s2.e_pre + {9'd0, mant_inc[23]};
        res_d    = '0;
        flg_d    = '0;
        if (s2.fmt) begin
            res_d = int_word;
        end else if (s2.zero) begin
            res_d = '0;
        end else if ($signed(e_rnd) >= 10'sd255) begin
            res_d = {s2.sign, 8'hFF, 23'h0};
            flg_d = 3'b101;
        end else if ($signed(e_rnd) <= 10'sd0) begin
            res_d = {s2.sign, 31'h0};
            flg_d = 3'b011;
        end else begin
            res_d = {s2.sign, e_rnd[7:0], mant_inc[22:0]};
            flg_d = {2'b00, guard | sticky};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_out <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (en) begin
            valid_out <= v2;
            result    <= res_d;
            flags     <= flg_d;
        end
    end

endmodule

// File: tb/tb_vx_tcu_drl_norm_round.sv
// Bench for vx_tcu_drl_norm_round: value-level fp32 model, scoreboard compare, directed vectors.
module tb_vx_tcu_drl_norm_round;

    localparam int W = 29;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         valid_in = 1'b0;
    logic         ready_in;
    logic [W-1:0] sig_in = '0;
    logic [7:0]   exp_in = '0;
    logic         fmt_sel = 1'b0;
    logic         valid_out;
    logic         ready_out = 1'b1;
    logic [31:0]  result;
    logic [2:0]   flags;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    vx_tcu_drl_norm_round #(.N(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .valid_in(valid_in), .ready_in(ready_in),
        .sig_in(sig_in), .exp_in(exp_in), .fmt_sel(fmt_sel),
        .valid_out(valid_out), .ready_out(ready_out),
        .result(result), .flags(flags)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Value-level reference: {flags, result} from sig * 2^(exp-150).
    function automatic logic [34:0] model(input logic [W-1:0] sig, input logic [7:0] e, input logic fmt);
        longint mag, q, rem, half;
        int p, ex;
        logic s;
        logic [2:0] fl;
        if (fmt) return {3'b000, 32'(sig)};
        s   = sig[W-1];
        mag = s ? ((longint'(1) << W) - longint'(sig)) : longint'(sig);
        if (mag == 0 || e == 8'd0) return 35'd0;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        fl = 3'b000;
        if (p >= 23) begin
            q   = mag >> (p - 23);
            rem = mag - (q << (p - 23));
            if (p > 23) begin
                half = longint'(1) << (p - 24);
                if (rem > half || (rem == half && q[0])) q++;
            end
            if (rem != 0) fl[0] = 1'b1;
        end else begin
            q = mag << (23 - p);
        end
        ex = int'(e) + p - 23;
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            ex++;
        end
        if (ex >= 255) return {3'b101, s, 8'hFF, 23'h0};
        if (ex <= 0) return {3'b011, s, 31'h0};
        return {fl, s, 8'(ex), 23'(q)};
    endfunction

    // Scoreboard: push on accepted input, compare head whenever output is valid.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %h with no beat outstanding", result);
                end else begin
                    check("out_result", result, exp_q[0][31:0]);
                    check("out_flags", flags, exp_q[0][34:32]);
                    if (ready_out) void'(exp_q.pop_front());
                end
            end
            if (valid_in && ready_in) exp_q.push_back(model(sig_in, exp_in, fmt_sel));
        end
    end

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic send(input logic [W-1:0] s, input logic [7:0] e, input logic f);
        int n = 0;
        sig_in = s; exp_in = e; fmt_sel = f; valid_in = 1'b1;
        @(negedge clk);
        while (!ready_in && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready_in got 0 expected 1");
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    logic [W-1:0] v_sig[18] = '{
        29'h0800000, 29'h1F800000, 29'h0000000, 29'h1000001, 29'h1000003, 29'h8000000,
        29'h0000001, 29'h1234567, 29'h10000000, 29'h0FFFFFF, 29'h1FFFFFF, 29'h0800000,
        29'h0800000, 29'h0800000, 29'h0400000, 29'h0000123, 29'h1FFFFFFF, 29'h1FFFFFFF};
    logic [7:0] v_exp[18] = '{
        8'd127, 8'd127, 8'd55, 8'd127, 8'd127, 8'd254,
        8'd1, 8'd0, 8'd127, 8'd127, 8'd127, 8'd254,
        8'd255, 8'd1, 8'd1, 8'd0, 8'd1, 8'd9};
    logic v_fmt[18] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready_in", ready_in, 1);

        // Hand-computed pins on the reference itself.
        check("pin_one", model(29'h0800000, 8'd127, 1'b0), {3'b000, 32'h3F800000});
        check("pin_neg_one", model(29'h1F800000, 8'd127, 1'b0), {3'b000, 32'hBF800000});
        check("pin_tie_even", model(29'h1000001, 8'd127, 1'b0), {3'b001, 32'h40000000});
        check("pin_round_up", model(29'h1000003, 8'd127, 1'b0), {3'b001, 32'h40000002});
        check("pin_ovf", model(29'h8000000, 8'd254, 1'b0), {3'b101, 32'h7F800000});
        check("pin_unf", model(29'h0000001, 8'd1, 1'b0), {3'b011, 32'h00000000});
        check("pin_carry", model(29'h1FFFFFF, 8'd127, 1'b0), {3'b001, 32'h40800000});
        check("pin_int", model(29'h1234567, 8'd0, 1'b1), {3'b000, 32'h01234567});

        // Single beat latency.
        @(posedge clk);
        #1;
        sig_in = 29'h0800000; exp_in = 8'd127; fmt_sel = 1'b0; valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 3);
        check("latency_result", result, 32'h3F800000);
        drain();

        // Directed table, back to back.
        for (int i = 0; i < 18; i++) send(v_sig[i], v_exp[i], v_fmt[i]);
        drain();

        // Stall: three beats in, downstream blocked for five cycles.
        ready_out = 1'b0;
        send(29'h1000003, 8'd127, 1'b0);
        send(29'h1F800000, 8'd127, 1'b0);
        send(29'h1234567, 8'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ready_in", ready_in, 0);
            check("stall_valid_out", valid_out, 1);
            check("stall_held_result", result, 32'h40000002);
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        drain();

        // Reset mid-stream discards everything in flight.
        send(29'h0800000, 8'd100, 1'b0);
        send(29'h0800000, 8'd101, 1'b0);
        send(29'h0800000, 8'd102, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid_out", valid_out, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_flags", flags, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready_in", ready_in, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        check("no_stale_beat", seen, 0);
        @(posedge clk);
        #1;
        send(29'h1000001, 8'd127, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
